// File: rtl/expr_arb_if.sv
// Bundle of the two requester streams, the recognizer link and the result port of expr_arb.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface expr_arb_if #(
    parameter int LEN_W = 4
);
    logic             req0_valid;
    logic [7:0]       req0_data;
    logic             req0_last;
    logic             req0_ready;
    logic             req1_valid;
    logic [7:0]       req1_data;
    logic             req1_last;
    logic             req1_ready;
    logic             chk_clr;
    logic             chk_en;
    logic [7:0]       chk_in;
    logic             chk_out;
    logic             res_valid;
    logic             res_ok;
    logic             res_id;
    logic [LEN_W-1:0] res_len;

    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output chk_clr, chk_en, chk_in,
        input  chk_out,
        output res_valid, res_ok, res_id, res_len
    );

    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  chk_clr, chk_en, chk_in,
        output chk_out,
        input  res_valid, res_ok, res_id, res_len
    );
endinterface

// File: rtl/expr_arb.sv
// Round-robin arbiter that lends one expression recognizer to two char streams, one whole
// expression at a time, and reports the verdict with owner id and forwarded length.
module expr_arb #(
    parameter int MAX_LEN = 15,
    parameter int LEN_W   = 4
) (
    input  logic       clk,
    input  logic       clr,
    expr_arb_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_JUDGE  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    state_t           r_state;
    logic             r_gnt;
    logic             r_ptr;
    logic [LEN_W-1:0] r_len;
    logic             r_ovf;
    logic             r_res_ok;
    logic             r_res_id;
    logic [LEN_W-1:0] r_res_len;

    state_t           w_state_nxt;
    logic             w_gnt_nxt;
    logic             w_rdy0;
    logic             w_rdy1;
    logic             w_chk_clr;
    logic             w_chk_en;
    logic [7:0]       w_chk_in;
    logic             w_res_valid;
    logic             w_xfer;
    logic             w_g_valid;
    logic [7:0]       w_g_data;
    logic             w_g_last;
    logic             w_room;

    assign w_g_valid = r_gnt ? bus.req1_valid : bus.req0_valid;
    assign w_g_data  = r_gnt ? bus.req1_data  : bus.req0_data;
    assign w_g_last  = r_gnt ? bus.req1_last  : bus.req0_last;
    assign w_room    = (r_len < MAX_LEN_C);
    // In STREAM the granted side is always ready, so its valid alone marks a transfer.
    assign w_xfer    = (r_state == ST_STREAM) && w_g_valid;

    // Next-state, grant selection and per-state handshake/recognizer controls.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_rdy0      = 1'b0;
        w_rdy1      = 1'b0;
        w_chk_clr   = 1'b0;
        w_chk_en    = 1'b0;
        w_chk_in    = 8'h00;
        w_res_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    // The pointer side wins a tie; a lone requester is always taken.
                    if (r_ptr == 1'b0) begin
                        w_gnt_nxt = bus.req0_valid ? 1'b0 : 1'b1;
                    end else begin
                        w_gnt_nxt = bus.req1_valid ? 1'b1 : 1'b0;
                    end
                    w_state_nxt = ST_CLEAR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_chk_clr   = 1'b1;
                w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                w_rdy0 = (r_gnt == 1'b0);
                w_rdy1 = (r_gnt == 1'b1);
                if (w_xfer) begin
                    if (w_room) begin
                        w_chk_en = 1'b1;
                        w_chk_in = w_g_data;
                    end else begin
                        w_chk_en = 1'b0;
                    end
                    if (w_g_last) begin
                        w_state_nxt = ST_JUDGE;
                    end else begin
                        w_state_nxt = ST_STREAM;
                    end
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_JUDGE: begin
                w_state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                w_res_valid = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, grant, length/overflow tracking, result capture and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 1'b0;
            r_ptr     <= 1'b0;
            r_len     <= {LEN_W{1'b0}};
            r_ovf     <= 1'b0;
            r_res_ok  <= 1'b0;
            r_res_id  <= 1'b0;
            r_res_len <= {LEN_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            case (r_state)
                ST_CLEAR: begin
                    r_len <= {LEN_W{1'b0}};
                    r_ovf <= 1'b0;
                end
                ST_STREAM: begin
                    // Chars past MAX_LEN are swallowed; the overflow flag vetoes the verdict.
                    if (w_xfer && w_room) begin
                        r_len <= r_len + {{(LEN_W-1){1'b0}}, 1'b1};
                    end else if (w_xfer) begin
                        r_ovf <= 1'b1;
                    end
                end
                ST_JUDGE: begin
                    r_res_ok  <= bus.chk_out & ~r_ovf;
                    r_res_id  <= r_gnt;
                    r_res_len <= r_len;
                end
                ST_REPORT: begin
                    r_ptr <= ~r_gnt;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.chk_clr    = w_chk_clr;
    assign bus.chk_en     = w_chk_en;
    assign bus.chk_in     = w_chk_in;
    assign bus.res_valid  = w_res_valid;
    assign bus.res_ok     = r_res_ok;
    assign bus.res_id     = r_res_id;
    assign bus.res_len    = r_res_len;

endmodule
